// File: rtl/gray_to_binary_decoder.sv
// Sequential Gray-to-binary decoder, MSB-first at one bit per clock, valid/ready on both sides.
// Optional G2B_STEP_CHECK_EN adds step_err: accepted word is not a single-bit step from the previous one.
module gray_to_binary_decoder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] g_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] b_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
`ifdef G2B_STEP_CHECK_EN
   ,
   output logic             step_err
`endif
);

   localparam int IDX_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] g_reg;
   logic [IDX_W-1:0] idx;
   logic [WIDTH:0]   g_ext;
   logic [WIDTH:0]   b_ext;
   logic             bit_nxt;
   logic [WIDTH-1:0] b_nxt;
   logic             accept;
   logic             take;
   logic             last;

   // Handshakes are qualified by registered state only, never by our own outputs.
   assign accept = in_valid && (state == IDLE);
   assign take   = out_ready && (state == DONE);
   assign last   = (idx == '0);

   // The zero pad above the MSB makes b[WIDTH-1] = g[WIDTH-1] fall out of the general rule.
   assign g_ext   = {1'b0, g_reg};
   assign b_ext   = {1'b0, b_out};
   assign bit_nxt = g_ext[idx] ^ b_ext[idx + IDX_W'(1)];
   assign b_nxt   = b_out | (WIDTH'(bit_nxt) << idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = DECODE;
         DECODE:  if (last)   state_nxt = DONE;
         DONE:    if (take)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == DECODE) || (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g_reg <= '0;
         b_out <= '0;
         idx   <= IDX_W'(WIDTH - 1);
      end else if (accept) begin
         g_reg <= g_in;
         b_out <= '0;
         idx   <= IDX_W'(WIDTH - 1);
      end else if (state == DECODE) begin
         b_out <= b_nxt;
         if (!last) idx <= idx - IDX_W'(1);
      end
   end

`ifdef G2B_STEP_CHECK_EN
   logic [WIDTH-1:0] prev_g;
   logic             prev_v;
   logic [WIDTH-1:0] diff;
   logic             one_hot;

   // Equal words give diff == 0 and are flagged as well.
   assign diff    = g_in ^ prev_g;
   assign one_hot = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_g   <= '0;
         prev_v   <= 1'b0;
         step_err <= 1'b0;
      end else if (accept) begin
         step_err <= prev_v && !one_hot;
         prev_g   <= g_in;
         prev_v   <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_gray_to_binary_decoder.sv
// Directed bench for gray_to_binary_decoder: WIDTH=4 and WIDTH=8 instances share clock and reset.
module tb_gray_to_binary_decoder;

   typedef struct {
      logic [3:0] g;
      logic [3:0] b;
      int         step;   // expected step_err, -1 = don't care
   } vec_t;

   logic       clk;
   logic       rst;
   logic [3:0] g4;
   logic       iv4, ir4, ov4, or4, busy4;
   logic [3:0] b4;
   logic [7:0] g8;
   logic       iv8, ir8, ov8, or8, busy8;
   logic [7:0] b8;
`ifdef G2B_STEP_CHECK_EN
   logic       se4, se8;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_t = 0;

   gray_to_binary_decoder #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .g_in(g4), .in_valid(iv4), .in_ready(ir4),
      .b_out(b4), .out_valid(ov4), .out_ready(or4), .busy(busy4)
`ifdef G2B_STEP_CHECK_EN
      , .step_err(se4)
`endif
   );

   gray_to_binary_decoder #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .g_in(g8), .in_valid(iv8), .in_ready(ir8),
      .b_out(b8), .out_valid(ov8), .out_ready(or8), .busy(busy8)
`ifdef G2B_STEP_CHECK_EN
      , .step_err(se8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Offer one word, wait for the accept edge and then for out_valid; check result and latency.
   task automatic send(input int w, input logic [31:0] g, input logic [31:0] exp_b,
                       input int exp_step, input string name);
      int n;
      int t;
      logic rdy, vld;
      logic [31:0] b;
      if (w == 4) begin g4 = g[3:0]; iv4 = 1'b1; end
      else        begin g8 = g[7:0]; iv8 = 1'b1; end
      n = 0;
      rdy = (w == 4) ? ir4 : ir8;
      while (!rdy && n < 50) begin
         @(posedge clk); #1; n++;
         rdy = (w == 4) ? ir4 : ir8;
      end
      if (n >= 50) chk({name, " accept timeout"}, 32'(rdy), 32'd1);
      @(posedge clk); #1;
      t = cyc;
      last_t = t;
      iv4 = 1'b0; iv8 = 1'b0;
      chk({name, " in_ready after accept"}, 32'((w == 4) ? ir4 : ir8), 32'd0);
      n = 0;
      vld = (w == 4) ? ov4 : ov8;
      while (!vld && n < 40) begin
         @(posedge clk); #1; n++;
         vld = (w == 4) ? ov4 : ov8;
      end
      b = (w == 4) ? 32'(b4) : 32'(b8);
      chk({name, " latency"}, 32'(cyc - t), 32'(w));
      chk({name, " b_out"}, b, exp_b);
`ifdef G2B_STEP_CHECK_EN
      if (exp_step >= 0)
         chk({name, " step_err"}, 32'((w == 4) ? se4 : se8), 32'(exp_step));
`endif
   endtask

   vec_t exh[16];
   vec_t stp[6];

   initial begin
      int prev_t;
      int bad;
      int n;

      exh = '{'{4'b0000, 4'd0, 0}, '{4'b0001, 4'd1, 0}, '{4'b0011, 4'd2, 0}, '{4'b0010, 4'd3, 0},
              '{4'b0110, 4'd4, 0}, '{4'b0111, 4'd5, 0}, '{4'b0101, 4'd6, 0}, '{4'b0100, 4'd7, 0},
              '{4'b1100, 4'd8, 0}, '{4'b1101, 4'd9, 0}, '{4'b1111, 4'd10, 0}, '{4'b1110, 4'd11, 0},
              '{4'b1010, 4'd12, 0}, '{4'b1011, 4'd13, 0}, '{4'b1001, 4'd14, 0}, '{4'b1000, 4'd15, 0}};
      stp = '{'{4'b0000, 4'b0000, 0}, '{4'b0001, 4'b0001, 0}, '{4'b0011, 4'b0010, 0},
              '{4'b0000, 4'b0000, 1}, '{4'b0000, 4'b0000, 1}, '{4'b0001, 4'b0001, 0}};

      rst = 1'b1;
      g4 = '0; iv4 = 1'b0; or4 = 1'b1;
      g8 = '0; iv8 = 1'b0; or8 = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("reset in_ready", 32'(ir4), 32'd1);
      chk("reset out_valid", 32'(ov4), 32'd0);
      chk("reset busy", 32'(busy4), 32'd0);
      chk("reset b_out", 32'(b4), 32'd0);
`ifdef G2B_STEP_CHECK_EN
      chk("reset step_err", 32'(se4), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Single decode.
      send(4, 32'b1101, 32'b1001, 0, "single");
      chk("single busy in DONE", 32'(busy4), 32'd1);

      // Reset two cycles into DECODE of 1101.
      @(posedge clk); #1;
      g4 = 4'b1101; iv4 = 1'b1;
      n = 0;
      while (!ir4 && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid-decode busy", 32'(busy4), 32'd1);
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(ov4), 32'd0);
      chk("async rst b_out", 32'(b4), 32'd0);
      chk("async rst in_ready", 32'(ir4), 32'd1);
      chk("async rst busy", 32'(busy4), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(4, 32'b0001, 32'b0001, 0, "post-reset");

      // Exhaustive back-to-back from a fresh reset.
      do_reset();
      prev_t = 0;
      for (int i = 0; i < 16; i++) begin
         send(4, 32'(exh[i].g), 32'(exh[i].b), exh[i].step, $sformatf("exh[%0d]", i));
         if (i > 0) chk($sformatf("exh[%0d] accept interval", i), 32'(last_t - prev_t), 32'd6);
         prev_t = last_t;
      end

      // Backpressure with a pending new word.
      @(posedge clk); #1;
      or4 = 1'b0;
      send(4, 32'b1101, 32'b1001, -1, "bp");
      g4 = 4'b0001; iv4 = 1'b1;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (b4 !== 4'b1001 || ov4 !== 1'b1 || ir4 !== 1'b0) bad++;
      end
      chk("bp stall cycles disturbed", 32'(bad), 32'd0);
      or4 = 1'b1;
      @(posedge clk); #1;
      chk("bp handshake out_valid", 32'(ov4), 32'd0);
      chk("bp handshake in_ready", 32'(ir4), 32'd1);
      chk("bp held b_out", 32'(b4), 32'b1001);
      @(posedge clk); #1;
      iv4 = 1'b0;
      chk("bp second accept busy", 32'(busy4), 32'd1);
      n = 0;
      while (!ov4 && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp second word b_out", 32'(b4), 32'b0001);

      // WIDTH=8 instance.
      send(8, 32'hFF, 32'hAA, 0, "w8 FF");
      send(8, 32'h80, 32'hFF, -1, "w8 80");

      // Step-check sequence, then reset and one more word.
      do_reset();
      for (int i = 0; i < 6; i++)
         send(4, 32'(stp[i].g), 32'(stp[i].b), stp[i].step, $sformatf("step[%0d]", i));
      do_reset();
      send(4, 32'b1111, 32'b1010, 0, "step after reset");

      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
